// File: rtl/alu_pkg.sv
// alu_pkg -- shared constants and types for the sequential accumulator ALU.
//
// Contents:
//   ALU_W        datapath width (8)
//   alu_op_e     3-bit operation codes OP_ADD .. OP_MUL
//   alu_state_e  control FSM states S_IDLE, S_MUL, S_DONE
//
// Optional feature macro used by the ALU: ALU_MUL_EN (multi-cycle multiply).
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if -- request/response bundle between the control unit and the ALU.
//
// Signals:
//   start   request strobe, sampled on a rising clock edge when not busy
//   op      3-bit operation code, latched with start
//   a, b    operands (a = accumulator, b = register/immediate)
//   busy    high while a multiply iterates
//   done    one-cycle completion strobe (used as LoadAcc)
//   result  registered result, held until the next completion
//   zero    registered result==0 flag
//   carry   registered carry/borrow/overflow flag
//
// Modports: master (control unit / bench side), slave (ALU side).
interface alu_seq_if;
  import alu_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [ALU_W-1:0] a;
  logic [ALU_W-1:0] b;
  logic             busy;
  logic             done;
  logic [ALU_W-1:0] result;
  logic             zero;
  logic             carry;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, carry
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, carry
  );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq -- 8-step shift-add multiplier, multiplier LSB first.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   load     latch operands a/b and clear the partial product
//   step     perform one shift-add iteration
//   a, b     multiplicand / multiplier (sampled on load)
//   product  16-bit partial product *including* the iteration performed on
//            the coming edge, so the owner can capture the final product on
//            the same edge as the 8th step.
//
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [ALU_W-1:0]     a,
  input  logic [ALU_W-1:0]     b,
  output logic [2*ALU_W-1:0]   product
);

  logic [2*ALU_W-1:0] mcand_q;
  logic [ALU_W-1:0]   mplr_q;
  logic [2*ALU_W-1:0] prod_q;

  // Look-ahead of the accumulated product after the current iteration.
  assign product = prod_q + (mplr_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
    end else if (load) begin
      mcand_q <= {{ALU_W{1'b0}}, a};
      mplr_q  <= b;
      prod_q  <= '0;
    end else if (step) begin
      prod_q  <= product;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- sequential 8-bit ALU for the accumulator datapath.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 = reset)
//   bus    alu_seq_if.slave: start/op/a/b in, busy/done/result/zero/carry out
//
// Single-cycle ops complete one cycle after acceptance. With ALU_MUL_EN
// defined, op 111 runs an 8-step shift-add multiply (latency 9, busy for
// 8 cycles); without it, op 111 is a single-cycle pass-through of a.
module alu_seq
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  alu_state_e       state_q, state_d;
  alu_op_e          op_in;
  logic             accept;
  logic             is_mul_req;
  logic             last_step;
  logic [ALU_W:0]   add_sum;
  logic [ALU_W-1:0] alu_res;
  logic             alu_carry;
  logic [ALU_W-1:0] result_q;
  logic             zero_q;
  logic             carry_q;

  assign op_in   = alu_op_e'(bus.op);
  // A request is taken in IDLE and in DONE (back-to-back), never in MUL.
  assign accept  = bus.start && (state_q != S_MUL);
  assign add_sum = {1'b0, bus.a} + {1'b0, bus.b};

`ifdef ALU_MUL_EN
  logic [2:0]         iter_cnt;
  logic [2*ALU_W-1:0] mul_product;

  assign is_mul_req = (op_in == OP_MUL);
  assign last_step  = (state_q == S_MUL) && (iter_cnt == 3'd7);

  // Iteration counter: cleared on accept, advances once per multiply cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_cnt <= 3'd0;
    end else if (accept && is_mul_req) begin
      iter_cnt <= 3'd0;
    end else if (state_q == S_MUL) begin
      iter_cnt <= iter_cnt + 3'd1;
    end
  end

  alu_mul_seq u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (accept && is_mul_req),
    .step    (state_q == S_MUL),
    .a       (bus.a),
    .b       (bus.b),
    .product (mul_product)
  );

  assign bus.busy = (state_q == S_MUL);
`else
  assign is_mul_req = 1'b0;
  assign last_step  = 1'b0;
  assign bus.busy   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE behaves like IDLE for new requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = is_mul_req ? S_MUL : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle datapath; op 111 defaults to a pass-through of a, which is
  // the result used when the multiplier is not built.
  always_comb begin
    alu_res   = bus.a;
    alu_carry = 1'b0;
    case (op_in)
      OP_ADD: begin
        alu_res   = add_sum[ALU_W-1:0];
        alu_carry = add_sum[ALU_W];
      end
      OP_SUB: begin
        alu_res   = bus.a - bus.b;
        alu_carry = (bus.a < bus.b);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_NOT: alu_res = ~bus.a;
      OP_SHL: begin
        alu_res   = {bus.a[ALU_W-2:0], 1'b0};
        alu_carry = bus.a[ALU_W-1];
      end
      default: begin
        alu_res   = bus.a;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Result and flags move only on a completion edge: the accept edge of a
  // single-cycle op, or the edge of the final multiply step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
    end else if (accept && !is_mul_req) begin
      result_q <= alu_res;
      zero_q   <= (alu_res == '0);
      carry_q  <= alu_carry;
`ifdef ALU_MUL_EN
    end else if (last_step) begin
      result_q <= mul_product[ALU_W-1:0];
      zero_q   <= (mul_product[ALU_W-1:0] == '0);
      carry_q  <= |mul_product[2*ALU_W-1:ALU_W];
`endif
    end
  end

  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.carry  = carry_q;

endmodule
